// File: rtl/range_frame_tx_if.sv
// Handshake and line signals of the range-frame UART transmitter.
// master: the frame source (drives bcd_in/start); slave: the transmitter.
interface range_frame_tx_if;
  logic [15:0] bcd_in;
  logic        start;
  logic        ready;
  logic        tx;
  logic        frame_done;

  modport master (
    output bcd_in,
    output start,
    input  ready,
    input  tx,
    input  frame_done
  );

  modport slave (
    input  bcd_in,
    input  start,
    output ready,
    output tx,
    output frame_done
  );
endinterface

// File: rtl/range_frame_tx.sv
// range_frame_tx: serialises a 3-digit BCD range as 'R' + three ASCII digits
// (+ CR when RANGE_FRAME_CR_EN is defined) onto an 8N1 UART line.
// Optional feature macro: RANGE_FRAME_CR_EN (appends 8'h0D, 5-byte frame).
module range_frame_tx #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic           clock,
  input  logic           reset_n,
  range_frame_tx_if.slave bus
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W        = 3;
`ifdef RANGE_FRAME_CR_EN
  localparam int unsigned NUM_BYTES    = 5;
`else
  localparam int unsigned NUM_BYTES    = 4;
`endif
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] BYTE_LAST = IDX_W'(NUM_BYTES - 1);
  localparam logic [7:0]       CHAR_R    = 8'h52;
  localparam logic [7:0]       CHAR_0    = 8'h30;
`ifdef RANGE_FRAME_CR_EN
  localparam logic [7:0]       CHAR_CR   = 8'h0D;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [IDX_W-1:0] byte_q, byte_d;
  logic [7:0]       shift_q, shift_d;
  logic [11:0]      digits_q, digits_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  // Upper nibble of bcd_in carries no digit.
  logic unused_hi;
  assign unused_hi = ^bus.bcd_in[15:12];

  // Non-decimal nibbles are shown as '9'.
  function automatic logic [3:0] clamp_digit(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  // Character at position idx of the frame, from the captured digits.
  function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx,
                                            input logic [11:0] dig);
    logic [7:0] b;
    case (idx)
      3'd0:    b = CHAR_R;
      3'd1:    b = CHAR_0 + {4'h0, dig[11:8]};
      3'd2:    b = CHAR_0 + {4'h0, dig[7:4]};
      3'd3:    b = CHAR_0 + {4'h0, dig[3:0]};
`ifdef RANGE_FRAME_CR_EN
      3'd4:    b = CHAR_CR;
`endif
      default: b = CHAR_R;
    endcase
    return b;
  endfunction

  // State and datapath registers; synchronous active-low reset aborts any frame.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      shift_q  <= '0;
      digits_q <= '0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      shift_q  <= shift_d;
      digits_q <= digits_d;
      tx_q     <= tx_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic; tx_d is the line level for the cycle after this edge.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    shift_d  = shift_q;
    digits_d = digits_q;
    tx_d     = tx_q;
    ready_d  = ready_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        if (bus.start && ready_q) begin
          digits_d = {clamp_digit(bus.bcd_in[11:8]),
                      clamp_digit(bus.bcd_in[7:4]),
                      clamp_digit(bus.bcd_in[3:0])};
          shift_d  = CHAR_R;
          byte_d   = '0;
          baud_d   = '0;
          state_d  = ST_START;
          tx_d     = 1'b0;
          ready_d  = 1'b0;
        end
      end

      ST_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d  = baud_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (byte_q == BYTE_LAST) begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
            ready_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            byte_d  = byte_q + IDX_W'(1);
            shift_d = frame_byte(byte_q + IDX_W'(1), digits_q);
            state_d = ST_START;
            tx_d    = 1'b0;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  assign bus.tx         = tx_q;
  assign bus.ready      = ready_q;
  assign bus.frame_done = done_q;

endmodule
